fwd_hazard_unit: RTL

- Parametrised successor to the EX-stage forwarding logic; generalises bypassing to NUM_STAGES producer stages, youngest first.
- Adds load-use stall detection and a registered scoreboard for variable-latency ops (divider, cache-miss loads).
- Adds a stall watchdog with a sticky error flag.
- Sits in EX beside the operand muxes; drives mux selects and pipeline stall.

---
 rtl/fwd_hazard_unit_pkg.sv | 15 +
 rtl/fwd_hazard_unit_if.sv | 47 ++++
 rtl/fwd_hazard_unit_scoreboard.sv | 53 +++++
 rtl/fwd_hazard_unit.sv | 146 ++++++++++++++
 4 files changed

// File: rtl/fwd_hazard_unit_pkg.sv
// Shared types and helpers for the EX-stage forwarding/hazard unit.
// Imported by the interface-facing top and the scoreboard.
package fwd_pkg;

    localparam int DEF_REG_AW = 5;
    localparam int FWD_SEL_RF = 0;

    typedef logic [DEF_REG_AW-1:0] reg_idx_t;

    // Forward select value that routes stage i onto an operand.
    function automatic int stage_sel(input int i);
        return i + 1;
    endfunction

endpackage

// File: rtl/fwd_hazard_unit_if.sv
// Operand/stage/issue bundle between EX control and the hazard unit.
// master drives EX state, slave is the hazard unit.
interface fwd_hazard_if #(
    parameter int REG_AW     = 5,
    parameter int NUM_REGS   = 32,
    parameter int NUM_STAGES = 2,
    parameter int SEL_W      = $clog2(NUM_STAGES + 1)
);

    logic [REG_AW-1:0]            rs1;
    logic [REG_AW-1:0]            rs2;
    logic                         rs1_used;
    logic                         rs2_used;
    logic [NUM_STAGES-1:0]        stg_wen;
    logic [NUM_STAGES*REG_AW-1:0] stg_rd;
    logic [NUM_STAGES-1:0]        stg_is_load;
    logic                         issue_valid;
    logic                         issue_long;
    logic [REG_AW-1:0]            issue_rd;
    logic                         lw_valid;
    logic [REG_AW-1:0]            lw_rd;
    logic                         flush;
    logic [SEL_W-1:0]             fwd_a;
    logic [SEL_W-1:0]             fwd_b;
    logic                         stall;
    logic [NUM_REGS-1:0]          busy_vec;
    logic                         tmo_err;

    modport master (
        output rs1, rs2, rs1_used, rs2_used,
        output stg_wen, stg_rd, stg_is_load,
        output issue_valid, issue_long, issue_rd,
        output lw_valid, lw_rd, flush,
        input  fwd_a, fwd_b, stall,
        input  busy_vec, tmo_err
    );

    modport slave (
        input  rs1, rs2, rs1_used, rs2_used,
        input  stg_wen, stg_rd, stg_is_load,
        input  issue_valid, issue_long, issue_rd,
        input  lw_valid, lw_rd, flush,
        output fwd_a, fwd_b, stall,
        output busy_vec, tmo_err
    );

endinterface

// File: rtl/fwd_hazard_unit_scoreboard.sv
// Busy-bit scoreboard for variable-latency destinations.
// Set beats clear on the same register; x0 is never busy.
module fwd_scoreboard
    import fwd_pkg::*;
#(
    parameter int REG_AW   = DEF_REG_AW,
    parameter int NUM_REGS = 32
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   set_en,
    input  logic [REG_AW-1:0]      set_idx,
    input  logic                   clr_en,
    input  logic [REG_AW-1:0]      clr_idx,
    input  logic [2:0][REG_AW-1:0] lk_idx,
    output logic [2:0]             busy,
    output logic [NUM_REGS-1:0]    busy_vec
);

    logic [NUM_REGS-1:0] busy_q;
    logic [NUM_REGS-1:0] set_mask;
    logic [NUM_REGS-1:0] clr_mask;
    logic [NUM_REGS-1:0] busy_nxt;

    // Decode set/clear requests into one-hot masks, x0 excluded.
    always_comb begin
        set_mask = '0;
        clr_mask = '0;
        if (set_en && set_idx != '0)
            set_mask[set_idx] = 1'b1;
        if (clr_en && clr_idx != '0)
            clr_mask[clr_idx] = 1'b1;
        busy_nxt = (busy_q & ~clr_mask) | set_mask;
    end

    // Busy bit register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            busy_q <= '0;
        else
            busy_q <= busy_nxt;
    end

    // Lookups for rs1, rs2 and the issuing destination.
    always_comb begin
        busy = '0;
        for (int k = 0; k < 3; k++)
            busy[k] = busy_q[lk_idx[k]];
    end

    assign busy_vec = busy_q;

endmodule

// File: rtl/fwd_hazard_unit.sv
// EX-stage forwarding select, load-use/scoreboard/WAW stall, watchdog.
// Optional perf counters when FWD_HAZARD_PERF_EN is defined.
module fwd_hazard_unit
    import fwd_pkg::*;
#(
    parameter int REG_AW     = DEF_REG_AW,
    parameter int NUM_REGS   = 32,
    parameter int NUM_STAGES = 2,
    parameter int SEL_W      = $clog2(NUM_STAGES + 1),
    parameter int STALL_TMO  = 255
) (
    input  logic        clk,
    input  logic        rst_n,
`ifdef FWD_HAZARD_PERF_EN
    output logic [31:0] perf_stall_lu,
    output logic [31:0] perf_stall_sb,
    output logic [31:0] perf_fwd_cnt,
`endif
    fwd_hazard_if.slave bus
);

    localparam int CNT_W = $clog2(STALL_TMO + 1);
    localparam logic [CNT_W-1:0] TMO_V = CNT_W'(STALL_TMO);

    logic [SEL_W-1:0]  sel_a;
    logic [SEL_W-1:0]  sel_b;
    logic              hit_a;
    logic              hit_b;
    logic              ld_a;
    logic              ld_b;
    logic [REG_AW-1:0] rd_i;

    logic [2:0]        sb_busy;
    logic              sb_a;
    logic              sb_b;
    logic              waw;
    logic              lu_any;
    logic              sb_any;
    logic              stall;
    logic              set_en;

    logic [CNT_W-1:0]  cnt_q;
    logic [CNT_W-1:0]  cnt_nxt;
    logic              tmo_q;

    // Youngest matching stage wins; scan oldest to youngest.
    always_comb begin
        sel_a = SEL_W'(FWD_SEL_RF);
        sel_b = SEL_W'(FWD_SEL_RF);
        hit_a = 1'b0;
        hit_b = 1'b0;
        ld_a  = 1'b0;
        ld_b  = 1'b0;
        rd_i  = '0;
        for (int i = NUM_STAGES - 1; i >= 0; i--) begin
            rd_i = bus.stg_rd[i*REG_AW +: REG_AW];
            if (bus.stg_wen[i] && rd_i != '0 &&
                rd_i == bus.rs1 && bus.rs1_used) begin
                sel_a = SEL_W'(stage_sel(i));
                hit_a = 1'b1;
                ld_a  = bus.stg_is_load[i];
            end
            if (bus.stg_wen[i] && rd_i != '0 &&
                rd_i == bus.rs2 && bus.rs2_used) begin
                sel_b = SEL_W'(stage_sel(i));
                hit_b = 1'b1;
                ld_b  = bus.stg_is_load[i];
            end
        end
    end

    // Hazard terms; same-cycle writeback is covered by write-through.
    always_comb begin
        sb_a = bus.rs1_used && sb_busy[0] && !hit_a &&
               !(bus.lw_valid && bus.lw_rd == bus.rs1);
        sb_b = bus.rs2_used && sb_busy[1] && !hit_b &&
               !(bus.lw_valid && bus.lw_rd == bus.rs2);
        waw  = bus.issue_valid && bus.issue_long && sb_busy[2] &&
               !(bus.lw_valid && bus.lw_rd == bus.issue_rd);
        lu_any = ld_a || ld_b;
        sb_any = sb_a || sb_b || waw;
        stall  = (lu_any || sb_any) && !bus.flush;
        set_en = bus.issue_valid && bus.issue_long && !stall &&
                 !bus.flush && bus.issue_rd != '0;
    end

    fwd_scoreboard #(
        .REG_AW   (REG_AW),
        .NUM_REGS (NUM_REGS)
    ) u_sb (
        .clk      (clk),
        .rst_n    (rst_n),
        .set_en   (set_en),
        .set_idx  (bus.issue_rd),
        .clr_en   (bus.lw_valid),
        .clr_idx  (bus.lw_rd),
        .lk_idx   ({bus.issue_rd, bus.rs2, bus.rs1}),
        .busy     (sb_busy),
        .busy_vec (bus.busy_vec)
    );

    // Watchdog count: run while stalled, saturate at the limit.
    always_comb begin
        if (!stall)
            cnt_nxt = '0;
        else if (cnt_q == TMO_V)
            cnt_nxt = cnt_q;
        else
            cnt_nxt = cnt_q + 1'b1;
    end

    // Watchdog counter and sticky timeout flag.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
            tmo_q <= 1'b0;
        end else begin
            cnt_q <= cnt_nxt;
            tmo_q <= tmo_q || (cnt_nxt == TMO_V);
        end
    end

`ifdef FWD_HAZARD_PERF_EN
    // Saturating stall-cause and forwarding-activity counters.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            perf_stall_lu <= '0;
            perf_stall_sb <= '0;
            perf_fwd_cnt  <= '0;
        end else begin
            if (stall && lu_any && perf_stall_lu != '1)
                perf_stall_lu <= perf_stall_lu + 1'b1;
            if (stall && sb_any && perf_stall_sb != '1)
                perf_stall_sb <= perf_stall_sb + 1'b1;
            if ((hit_a || hit_b) && perf_fwd_cnt != '1)
                perf_fwd_cnt <= perf_fwd_cnt + 1'b1;
        end
    end
`endif

    assign bus.fwd_a   = sel_a;
    assign bus.fwd_b   = sel_b;
    assign bus.stall   = stall;
    assign bus.tmo_err = tmo_q;

endmodule
